stack_engine: RTL and testbench

Parametrised hardware stack for the multicycle processor: it replaces the fixed SP adder, ZSP holding register and data-memory push/pop path with a self-contained unit. The unit owns a private stack RAM and a stack pointer, and executes PUSH/POP/PEEK/CLEAR commands through a valid/ready command port and a valid/ready response port. The control FSM drives it for call/return and explicit push/pop instructions, and reads `sp_addr` where the ISA exposes SP.

---
 rtl/stack_engine_pkg.sv | 25 ++
 rtl/stack_engine_if.sv | 35 +++
 rtl/stack_engine_ram.sv | 34 +++
 rtl/stack_engine.sv | 184 ++++++++++++++++++
 tb/tb_stack_engine.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_engine_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types and constants for the stack engine.
//   stack_op_t    : command opcodes carried on cmd_op (PUSH/POP/PEEK/CLEAR)
//   stack_state_t : control FSM states (IDLE/ACCESS/RESP)
//   WORD_BYTES    : byte stride between adjacent stack entries in sp_addr
// -----------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [1:0] {
    PUSH  = 2'd0,
    POP   = 2'd1,
    PEEK  = 2'd2,
    CLEAR = 2'd3
  } stack_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stack_state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/stack_engine_if.sv
// -----------------------------------------------------------------------------
// stack_engine_if
// Command / response handshake bundle between the processor control FSM
// (master) and the stack engine (slave).
//   cmd_valid/cmd_ready  : command handshake
//   cmd_op               : 0 PUSH, 1 POP, 2 PEEK, 3 CLEAR
//   cmd_data             : word to push
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data             : popped/peeked/pushed word, 0 for CLEAR and rejects
//   rsp_err              : command was rejected (guard build only)
// -----------------------------------------------------------------------------
interface stack_engine_if #(
  parameter int DATA_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/stack_engine_ram.sv
// -----------------------------------------------------------------------------
// stack_ram
// DEPTH x DATA_W private stack storage. Synchronous write, registered read.
// No reset: contents and the read register are undefined until written.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request; data appears on rdata_o after the edge
//   rdata_o          : read register, holds its value while re_i is low
// -----------------------------------------------------------------------------
module stack_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_engine.sv
// -----------------------------------------------------------------------------
// stack_engine
// Downward-growing hardware stack with a private RAM and stack pointer.
// One command is processed at a time: IDLE (accept) -> ACCESS (RAM/pointer
// update) -> RESP (hold response until consumed) -> IDLE.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : stack_engine_if slave (command + response handshakes)
//   sp_addr      : BASE_ADDR + 4*sp, byte address of the current top
//   count        : occupied entries (DEPTH - sp)
//   full / empty : sp == 0 / sp == DEPTH
//   ovf_sticky   : a PUSH was rejected since the last CLEAR/reset
//   unf_sticky   : a POP/PEEK was rejected since the last CLEAR/reset
//
// Build option: define STACK_ENGINE_GUARD_EN to report rejected commands via
// rsp_err and the sticky flags. Without it rejects are silently dropped and
// rsp_err/ovf_sticky/unf_sticky stay 0.
// -----------------------------------------------------------------------------
module stack_engine
  import stack_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SP_W      = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  stack_engine_if.slave   bus,
  output logic [31:0]     sp_addr,
  output logic [SP_W-1:0] count,
  output logic            full,
  output logic            empty,
  output logic            ovf_sticky,
  output logic            unf_sticky
);

`ifdef STACK_ENGINE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  // DEPTH is a power of two, so the pointer is exactly one bit wider than
  // the RAM address (the extra bit encodes the empty value DEPTH).
  localparam int              AW       = SP_W - 1;
  localparam logic [SP_W-1:0] SP_EMPTY = SP_W'(DEPTH);

  stack_state_t      state_q, state_d;
  stack_op_t         op_q;
  logic [DATA_W-1:0] data_q;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              from_ram_q, from_ram_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              in_access;
  logic              is_push, is_read;
  logic              rejected;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign full  = (sp_q == '0);
  assign empty = (sp_q == SP_EMPTY);
  assign count = SP_EMPTY - sp_q;
  assign sp_addr = BASE_ADDR + (32'(sp_q) * WORD_BYTES);

  assign in_access = (state_q == ACCESS);
  assign is_push   = (op_q == PUSH);
  assign is_read   = (op_q == POP) || (op_q == PEEK);
  assign rejected  = (is_push && full) || (is_read && empty);

  // Gating with rst keeps a reset landing in ACCESS from writing the RAM.
  assign ram_we = in_access && is_push && !full && !rst;
  assign ram_re = in_access && is_read && !empty;

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    // Low bits minus one wrap correctly for sp = DEPTH (low bits all zero).
    .waddr_i (sp_q[AW-1:0] - AW'(1)),
    .wdata_i (data_q),
    .re_i    (ram_re),
    .raddr_i (sp_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    rsp_data_d = rsp_data_q;
    from_ram_d = from_ram_q;
    rsp_err_d  = rsp_err_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) state_d = ACCESS;
      end
      ACCESS: begin
        state_d    = RESP;
        rsp_data_d = '0;
        from_ram_d = 1'b0;
        rsp_err_d  = GuardEn && rejected;
        case (op_q)
          PUSH: begin
            if (!full) begin
              sp_d       = sp_q - SP_W'(1);
              rsp_data_d = data_q;
            end else begin
              ovf_d = ovf_q | GuardEn;
            end
          end
          POP: begin
            if (!empty) begin
              sp_d       = sp_q + SP_W'(1);
              from_ram_d = 1'b1;
            end else begin
              unf_d = unf_q | GuardEn;
            end
          end
          PEEK: begin
            if (!empty) from_ram_d = 1'b1;
            else        unf_d      = unf_q | GuardEn;
          end
          default: begin
            sp_d  = SP_EMPTY;
            ovf_d = 1'b0;
            unf_d = 1'b0;
          end
        endcase
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sp_q       <= SP_EMPTY;
      rsp_data_q <= '0;
      from_ram_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      rsp_data_q <= rsp_data_d;
      from_ram_q <= from_ram_d;
      rsp_err_q  <= rsp_err_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Command capture: only the accept edge matters, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.cmd_valid) begin
      op_q   <= stack_op_t'(bus.cmd_op);
      data_q <= bus.cmd_data;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  // Successful POP/PEEK data comes straight from the RAM read register, which
  // is only loaded in ACCESS and therefore stays stable throughout RESP.
  assign bus.rsp_data  = from_ram_q ? ram_rdata : rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign ovf_sticky    = ovf_q;
  assign unf_sticky    = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// -----------------------------------------------------------------------------
// tb_stack_engine
// Scoreboard bench for stack_engine (DEPTH=4, DATA_W=32, BASE_ADDR=0x100).
// The driver applies each command to a queue-based stack model and pushes
// the expected response; a negedge monitor pops and compares on every
// response handshake. Status outputs are checked against the model after
// each command completes.
// -----------------------------------------------------------------------------
module tb_stack_engine;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h100;
`ifdef STACK_ENGINE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sp_addr;
  logic [2:0]  count;
  logic        full, empty, ovf_sticky, unf_sticky;

  stack_engine_if #(.DATA_W(32)) bus ();

  stack_engine #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sp_addr    (sp_addr),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [31:0] mdl[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Stack semantics at the command level: a bounded LIFO of words.
  task automatic model_apply(input logic [1:0] op, input logic [31:0] d, output exp_t e);
    e.data = '0;
    e.err  = 1'b0;
    case (op)
      2'd0: begin
        if (mdl.size() == DEPTH) begin
          e.err = GUARD;
          m_ovf = m_ovf | GUARD;
        end else begin
          mdl.push_back(d);
          e.data = d;
        end
      end
      2'd1: begin
        if (mdl.size() == 0) begin
          e.err = GUARD;
          m_unf = m_unf | GUARD;
        end else begin
          e.data = mdl.pop_back();
        end
      end
      2'd2: begin
        if (mdl.size() == 0) begin
          e.err = GUARD;
          m_unf = m_unf | GUARD;
        end else begin
          e.data = mdl[$];
        end
      end
      default: begin
        mdl.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    endcase
  endtask

  task automatic chk_status(input string tag);
    int sz;
    sz = mdl.size();
    chk({tag, "_count"},   32'(count),      32'(sz));
    chk({tag, "_empty"},   32'(empty),      32'(sz == 0));
    chk({tag, "_full"},    32'(full),       32'(sz == DEPTH));
    chk({tag, "_sp_addr"}, sp_addr,         BASE + 32'(4 * (DEPTH - sz)));
    chk({tag, "_ovf"},     32'(ovf_sticky), 32'(m_ovf));
    chk({tag, "_unf"},     32'(unf_sticky), 32'(m_unf));
    chk({tag, "_cmd_rdy"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  // Issue one command; hold>0 keeps rsp_ready low for that many cycles of RESP.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] d, input int hold);
    exp_t e;
    int   w;
    bit   seen, got;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      return;
    end
    bus.rsp_ready = (hold == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk);
    model_apply(op, d, e);
    exp_q.push_back(e);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = $urandom;
    if (hold > 0) begin
      w = 0;
      while (!bus.rsp_valid && w < 10) begin
        @(negedge clk); w++;
      end
      chk("hold_rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_rsp_data",  bus.rsp_data,       e.data);
        chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
    end
    w   = 0;
    got = 1'b0;
    while (!got && w < 20) begin
      @(negedge clk);
      seen = bus.rsp_valid && bus.rsp_ready;
      @(posedge clk);
      w++;
      if (seen) got = 1'b1;
    end
    chk("rsp_handshake", 32'(got), 32'd1);
    if (hold == 0) chk("rsp_latency", 32'(w), 32'd2);
    #1;
    chk_status("post_cmd");
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h, want no response", bus.rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", bus.rsp_data,      e.data);
        chk("rsp_err",  32'(bus.rsp_err),  32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   nz;
    logic [31:0] w4;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  bus.rsp_data,       32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_count",     32'(count),         32'd0);
    chk("rst_empty",     32'(empty),         32'd1);
    chk("rst_full",      32'(full),          32'd0);
    chk("rst_ovf",       32'(ovf_sticky),    32'd0);
    chk("rst_unf",       32'(unf_sticky),    32'd0);
    chk("rst_sp_addr",   sp_addr,            32'h110);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_status("after_rst");

    // LIFO ordering and pointer stepping
    do_cmd(2'd0, 32'hA, 0); chk("sp_A", sp_addr, 32'h10C);
    do_cmd(2'd0, 32'hB, 0); chk("sp_B", sp_addr, 32'h108);
    do_cmd(2'd0, 32'hC, 0); chk("sp_C", sp_addr, 32'h104);
    chk("count_3", 32'(count), 32'd3);
    do_cmd(2'd1, 32'h0, 0);
    do_cmd(2'd1, 32'h0, 0);
    do_cmd(2'd1, 32'h0, 0); chk("sp_back", sp_addr, 32'h110);

    // Overflow
    for (int i = 0; i < DEPTH; i++) begin
      w4 = $urandom;
      do_cmd(2'd0, w4, 0);
    end
    chk("full_after_4", 32'(full), 32'd1);
    do_cmd(2'd0, 32'hDEAD, 0);
    chk("ovf_sp_addr", sp_addr, 32'h100);
    chk("ovf_sticky_val", 32'(ovf_sticky), 32'(GUARD));
    for (int i = 0; i < DEPTH; i++) do_cmd(2'd1, 32'h0, 0);

    // Underflow, then CLEAR
    do_cmd(2'd1, 32'h0, 0);
    chk("unf_sticky_val", 32'(unf_sticky), 32'(GUARD));
    do_cmd(2'd3, 32'h0, 0);
    chk("clr_ovf", 32'(ovf_sticky), 32'd0);
    chk("clr_unf", 32'(unf_sticky), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);

    // PEEK with back-pressure
    do_cmd(2'd0, 32'h55, 0);
    do_cmd(2'd2, 32'h0, 5);
    chk("peek_count", 32'(count), 32'd1);
    do_cmd(2'd1, 32'h0, 0);

    // Reset landing in ACCESS of a PUSH on an empty stack
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 32'h77;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nz = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) nz++;
    end
    chk("rst_access_no_rsp", 32'(nz), 32'd0);
    @(posedge clk); #1;
    chk("rst_access_sp_addr", sp_addr, 32'h110);
    chk_status("rst_access");
    do_cmd(2'd0, 32'h1234_5678, 0);
    do_cmd(2'd1, 32'h0, 0);

    // Randomised traffic
    for (int n = 0; n < 80; n++) begin
      int r, h;
      logic [1:0] op;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      h  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      do_cmd(op, $urandom, h);
    end

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
